pipe_buf: RTL
=============

# pipe_buf

Parametrised elastic pipeline buffer between two stages of the core pipeline (fetch→decode, decode→execute, execute→memory, memory→writeback). It replaces fixed single-register stage latches with a DEPTH-entry FIFO under a valid/ready handshake, so a downstream stall no longer freezes the upstream stage. It also adds a synchronous flush for branch and exception redirects. The payload is opaque, so any packed stage struct (fetch_data_t, decode_data_t, execute_data_t, memory_data_t) can be carried by setting WIDTH to its $bits.

## Interface
- WIDTH, 96: payload width in bits (96 = fetch_data_t: 32-bit instr + 64-bit pc); legal ≥1.
- DEPTH, 2: number of entries; legal 1..16; need not be a power of two.
- CW, $clog2(DEPTH+1): derived width of count; not to be overridden.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (buffer resets while reset==0).
- in_valid  in  1  upstream offers in_data this cycle.
- in_ready  out  1  buffer can accept; enqueue happens when in_valid && in_ready.
- in_data  in  WIDTH  payload from upstream stage.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream accepts; dequeue happens when out_valid && out_ready.
- out_data  out  WIDTH  head entry payload.
- flush  in  1  discard all contents (redirect / exception).
- count  out  CW  number of valid entries, 0..DEPTH.

## Operation
- State:
  - storage mem[0..DEPTH-1]
  - wr_ptr and rd_ptr, each of width $clog2(DEPTH) (min 1)
  - count register
- Pointer wrap:
  - wr_ptr advances on every enqueue; rd_ptr advances on every dequeue.
  - Each pointer goes from DEPTH-1 back to 0 by explicit compare, not by power-of-two overflow.
- Outputs:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr].
  - All outputs are driven from registers only, with no combinational path from out_ready to in_ready and none from in_valid to out_valid.
- Simultaneous enqueue and dequeue:
  - count is unchanged; both pointers advance.
  - When full, in_ready is 0, so enqueue is blocked even if a dequeue happens in the same cycle (no pass-through when full).
- Flush:
  - Next edge: count=0, wr_ptr=0, rd_ptr=0.
  - Flush overrides any enqueue or dequeue in the same cycle; the offered in_data is dropped and upstream must treat it as consumed-and-killed.
  - Storage contents are not cleared.
- out_data is don't-care while out_valid==0.
- Handshake rule for upstream: once in_valid=1, in_data must stay stable until accepted or flushed. The buffer itself does not check this.
- Reset (reset==0, asynchronous):
  - count=0, wr_ptr=0, rd_ptr=0, so out_valid=0 and in_ready=1 immediately.
  - mem is not reset.
  - Reset asserted mid-transfer drops all entries; the first edge after reset releases behaves as a normal empty buffer.

## Timing
- Latency: data enqueued at edge N is presented on out_data with out_valid=1 after edge N (visible in cycle N+1). No same-cycle bypass.
- Throughput: one transfer per cycle sustained when 0 < count < DEPTH, or when count==DEPTH-1 with a concurrent dequeue.
- DEPTH=1: alternates full/empty, giving 50% throughput under continuous flow. This is legal and intended as the cheap latch replacement.
- in_ready falls in the cycle after the enqueue that fills the buffer. It rises in the cycle after the dequeue that frees a slot.
- After flush at edge N: out_valid=0 and in_ready=1 in cycle N+1; a new enqueue is accepted at edge N+1.
- count is always equal to the number of enqueues minus dequeues since the last reset or flush.

## Test plan
All scenarios use WIDTH=96, DEPTH=2 unless stated.
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, in_ready=1, count=0 throughout, including mid-cycle on reset assertion.
- Fill/drain: enqueue A=96'h1, B=96'h2 with out_ready=0 -> count=2, in_ready=0, out_data=1. Offered C is not accepted. Set out_ready=1 -> outputs 1 then 2 in order, count 2→1→0, and C is accepted only after in_ready returns.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles with an incrementing payload -> after 1 cycle of latency, out_data increments by 1 every cycle with no gaps or duplicates, and count stays at 1.
- Wrap with non-power-of-two: DEPTH=3, random valid/ready for 1000 cycles -> output sequence equals input sequence (scoreboard), count is never >3, and pointers wrap 2→0.
- Flush collision: count=2, with flush=1, in_valid=1 and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, and neither the dequeued nor the offered item is later observed.
- DEPTH=1 flow: continuous in_valid/out_ready -> a transfer every other cycle, and in_ready toggles 1,0,1,0.

Source files
------------

// File: rtl/pipe_buf.sv
// rtl/pipe_buf.sv - elastic DEPTH-entry valid/ready pipeline buffer with synchronous flush
module pipe_buf #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_enq;
  logic             do_deq;

  // Both flags come straight off the count register, so no handshake input reaches them.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  assign do_enq = in_valid && in_ready;
  assign do_deq = out_valid && out_ready;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= ptr_inc(wr_ptr);
      if (do_deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; a flushed enqueue must not land in it.
  always_ff @(posedge clk) begin
    if (do_enq && !flush) mem[wr_ptr] <= in_data;
  end

endmodule
